// File: rtl/ldpc_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ldpc_mem_pkg                                                         |
// | Shared types and parameter-legality helpers for LDPC message memory. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ldpc_mem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } clr_state_e;

    localparam int c_RD_LAT_MIN = 1;
    localparam int c_RD_LAT_MAX = 2;
    localparam int c_N_RD_MIN   = 1;
    localparam int c_N_RD_MAX   = 4;

    function automatic bit rd_lat_legal(input int lat);
        return (lat >= c_RD_LAT_MIN) && (lat <= c_RD_LAT_MAX);
    endfunction

    function automatic bit n_rd_legal(input int n);
        return (n >= c_N_RD_MIN) && (n <= c_N_RD_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ldpc_bram_clear_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ldpc_bram_clear_fsm                                                  |
// | Sweep controller that initialises every word of the message RAM.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ldpc_bram_clear_fsm
    import ldpc_mem_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    output logic              ready,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    clr_state_e        r_state;
    logic [ADDR_W:0]   r_cnt;
    logic              r_ready;
    logic              r_clr_we;
    logic [ADDR_W:0]   w_cnt_nxt;

    // The extra MSB flags the wrap past DEPTH-1, i.e. the last word was written.
    assign w_cnt_nxt = r_cnt + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_CLEAR;
            r_cnt    <= '0;
            r_ready  <= 1'b0;
            r_clr_we <= 1'b1;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (w_cnt_nxt[ADDR_W]) begin
                        r_state  <= ST_READY;
                        r_cnt    <= '0;
                        r_ready  <= 1'b1;
                        r_clr_we <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                ST_READY: begin
                    if (clr) begin
                        r_state  <= ST_CLEAR;
                        r_cnt    <= '0;
                        r_ready  <= 1'b0;
                        r_clr_we <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign ready    = r_ready;
    assign clr_we   = r_clr_we;
    assign clr_addr = r_cnt[ADDR_W-1:0];

endmodule
`default_nettype wire

// File: rtl/ldpc_msg_bram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ldpc_msg_bram                                                        |
// | Multi-read-port message/LLR RAM with hardware clear sweep.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ldpc_msg_bram
    import ldpc_mem_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 4,
    parameter int                N_RD     = 2,
    parameter int                RD_LAT   = 1,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic [N_RD-1:0]        rd_en,
    input  logic [N_RD*ADDR_W-1:0] rd_addr,
    output logic [N_RD*DATA_W-1:0] rd_data,
    output logic [N_RD-1:0]        rd_valid,
    output logic                   ready
);

    localparam int c_DEPTH = 1 << ADDR_W;

    if (!(rd_lat_legal(RD_LAT) && n_rd_legal(N_RD))) begin : g_param_check
        $error("ldpc_msg_bram: RD_LAT must be 1..2 and N_RD must be 1..4");
    end

    logic [DATA_W-1:0] r_mem [0:c_DEPTH-1];

    logic              w_ready;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_user_we;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_data;

    ldpc_bram_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .ready    (w_ready),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr)
    );

    // A clear request on the same edge takes priority and drops the user write.
    assign w_user_we  = w_ready & wr_en & ~clr;
    assign w_mem_we   = w_clr_we | w_user_we;
    assign w_mem_addr = w_clr_we ? w_clr_addr : wr_addr;
    assign w_mem_data = w_clr_we ? INIT_VAL   : wr_data;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    assign ready = w_ready;

    for (genvar gi = 0; gi < N_RD; gi++) begin : g_rd_port
        logic [ADDR_W-1:0] w_addr;
        logic              w_fire;
        logic              w_bypass;
        logic [DATA_W-1:0] r_q;

        assign w_addr   = rd_addr[gi*ADDR_W +: ADDR_W];
        assign w_fire   = w_ready & rd_en[gi];
        assign w_bypass = w_user_we & (wr_addr == w_addr);

        // Array-side read register: left unreset so it maps onto the RAM macro.
        always_ff @(posedge clk) begin
            if (w_fire) begin
                r_q <= w_bypass ? wr_data : r_mem[w_addr];
            end
        end

        if (RD_LAT == 1) begin : g_lat1
            logic r_vld;
            logic r_seen;

            // r_seen masks the unreset read register until it has been loaded.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_vld  <= 1'b0;
                    r_seen <= 1'b0;
                end else begin
                    r_vld <= w_fire;
                    if (w_fire) begin
                        r_seen <= 1'b1;
                    end
                end
            end

            assign rd_data[gi*DATA_W +: DATA_W] = r_seen ? r_q : '0;
            assign rd_valid[gi]                 = r_vld;
        end else begin : g_lat2
            logic [1:0]        r_vld;
            logic [DATA_W-1:0] r_out;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_vld <= '0;
                    r_out <= '0;
                end else begin
                    r_vld <= {r_vld[0], w_fire};
                    if (r_vld[0]) begin
                        r_out <= r_q;
                    end
                end
            end

            assign rd_data[gi*DATA_W +: DATA_W] = r_out;
            assign rd_valid[gi]                 = r_vld[1];
        end
    end

endmodule
`default_nettype wire
